// File: rtl/prog_fetch_seq.sv
// Instruction fetch sequencer in front of a 16x32 program memory.
// Executes JMP/HALT locally and hands every other word downstream via valid/ready.
module prog_fetch_seq #(
  parameter logic [3:0]  RESET_PC = 4'd0,
  parameter int unsigned MEM_LAT  = 1,
  parameter logic [3:0]  OP_JMP   = 4'hF,
  parameter logic [3:0]  OP_HALT  = 4'hE
) (
  input  logic        c,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  output logic [3:0]  mem_a,
  output logic        mem_ld,
  input  logic [31:0] mem_d,
  output logic [31:0] instr,
  output logic [3:0]  instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        busy,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_HALTED
  } state_t;

  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT);

  state_t     state;
  logic [3:0] pc;
  logic [2:0] lat_cnt;

  always_ff @(posedge c) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      lat_cnt     <= '0;
      mem_a       <= '0;
      mem_ld      <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
    end else if (stop) begin
      if (state != S_IDLE) begin
        state       <= S_IDLE;
        instr_valid <= 1'b0;
        mem_ld      <= 1'b0;
        halted      <= 1'b0;
        busy        <= 1'b0;
      end
    end else if (start && (state == S_IDLE || state == S_HALTED)) begin
      state  <= S_FETCH;
      pc     <= RESET_PC;
      mem_a  <= RESET_PC;
      mem_ld <= 1'b1;
      busy   <= 1'b1;
      halted <= 1'b0;
    end else begin
      // mem_ld/mem_a are set on entry to FETCH so the strobe lines up with that cycle
      case (state)
        S_FETCH: begin
          state   <= S_WAIT;
          mem_ld  <= 1'b0;
          lat_cnt <= LAT_LOAD;
        end
        S_WAIT: begin
          if (lat_cnt == 3'd1) begin
            if (mem_d[31:28] == OP_JMP) begin
              pc     <= mem_d[3:0];
              mem_a  <= mem_d[3:0];
              mem_ld <= 1'b1;
              state  <= S_FETCH;
            end else if (mem_d[31:28] == OP_HALT) begin
              state  <= S_HALTED;
              halted <= 1'b1;
              busy   <= 1'b0;
            end else begin
              instr       <= mem_d;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              pc          <= pc + 4'd1;
              state       <= S_HOLD;
            end
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= S_FETCH;
            mem_a       <= pc;
            mem_ld      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
